// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM capture block.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam int unsigned CNT_W_DEF       = 32;
   localparam int unsigned TIMEOUT_DEF     = 1000;
   localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes an asynchronous line and reports its rising/falling edges.
module pwm_edge_sync
   import pwm_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic sig_i,
   output logic s_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   dly_q;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
   assign s_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = s_o & ~dly_q;
   assign fall_o = ~s_o & dly_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         dly_q  <= s_o;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time per complete period;
// flags a line that stays at one level for TIMEOUT cycles.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             stuck_high,
   output logic             stuck_low
);

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] high_cap_q, high_cap_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;
   logic             mv_q, mv_d;
   logic             sh_q, sh_d;
   logic             sl_q, sl_d;

   logic s, rise, fall, edge_any, tmo;

   pwm_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clock (clock),
      .reset (reset),
      .sig_i (pwm_in),
      .s_o   (s),
      .rise_o(rise),
      .fall_o(fall)
   );

   assign edge_any = rise | fall;
   // An edge in the same cycle as the limit beats the timeout.
   assign tmo = (state_q != IDLE) && (cnt_q == TMO) && !edge_any;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (rise) state_d = HIGH;
            HIGH: begin
               if (rise)      state_d = HIGH;
               else if (fall) state_d = LOW;
               else if (tmo)  state_d = IDLE;
            end
            LOW: begin
               if (rise)     state_d = HIGH;
               else if (tmo) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      high_cap_d  = high_cap_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      mv_d        = 1'b0;
      sh_d        = sh_q;
      sl_d        = sl_q;
      if (!enable) begin
         sh_d = 1'b0;
         sl_d = 1'b0;
      end else begin
         if (edge_any) begin
            sh_d = 1'b0;
            sl_d = 1'b0;
         end
         if (rise)
            cnt_d = ONE;
         else if (state_q != IDLE && cnt_q != TMO)
            cnt_d = cnt_q + ONE;
         if (state_q == HIGH && fall)
            high_cap_d = cnt_q;
         if (state_q == LOW && rise) begin
            period_d    = cnt_q;
            high_time_d = high_cap_q;
            mv_d        = 1'b1;
         end
         if (tmo) begin
            sh_d = s;
            sl_d = ~s;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         high_cap_q  <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         mv_q        <= 1'b0;
         sh_q        <= 1'b0;
         sl_q        <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         high_cap_q  <= high_cap_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         mv_q        <= mv_d;
         sh_q        <= sh_d;
         sl_q        <= sl_d;
      end
   end

   assign period     = period_q;
   assign high_time  = high_time_q;
   assign meas_valid = mv_q;
   assign stuck_high = sh_q;
   assign stuck_low  = sl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture with TIMEOUT=50.
module tb_pwm_capture;

   localparam int CW = 32;

   logic          clock;
   logic          reset;
   logic          enable;
   logic          pwm_in;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          meas_valid;
   logic          stuck_high;
   logic          stuck_low;

   int checks   = 0;
   int failures = 0;

   int cyc      = 0;
   int mv_count = 0;
   int last_mv  = -1;
   int prev_mv  = -1;
   int consec   = 0;
   int both     = 0;
   logic mv_prev = 1'b0;

   pwm_capture #(
      .CNT_W      (CW),
      .TIMEOUT    (50),
      .SYNC_STAGES(2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .pwm_in    (pwm_in),
      .period    (period),
      .high_time (high_time),
      .meas_valid(meas_valid),
      .stuck_high(stuck_high),
      .stuck_low (stuck_low)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      cyc = cyc + 1;
      if (meas_valid) begin
         mv_count = mv_count + 1;
         prev_mv  = last_mv;
         last_mv  = cyc;
         if (mv_prev) consec = consec + 1;
      end
      if (stuck_high && stuck_low) both = both + 1;
      mv_prev = meas_valid;
   end

   task automatic hold(input logic v, input int n);
      pwm_in = v;
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string name, input logic [CW-1:0] act,
                      input logic [CW-1:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic test_reset;
      reset  = 1'b1;
      enable = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_period", period, 0);
      chk("rst_high", high_time, 0);
      chk("rst_mv", {31'd0, meas_valid}, 0);
      chk("rst_sh", {31'd0, stuck_high}, 0);
      chk("rst_sl", {31'd0, stuck_low}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_rel_period", period, 0);
   endtask

   task automatic test_gen_pattern;
      int base, c2, c3;
      hold(0, 5);
      base = mv_count;
      hold(1, 2);
      hold(0, 18);
      chk("gen_first_rise_no_mv", mv_count, base);
      c2 = cyc;
      hold(1, 2);
      hold(0, 18);
      chk("gen_mv_count1", mv_count, base + 1);
      chk("gen_mv_latency", last_mv, c2 + 3);
      chk("gen_period", period, 20);
      chk("gen_high", high_time, 2);
      c3 = cyc;
      hold(1, 2);
      hold(0, 18);
      chk("gen_mv_count2", mv_count, base + 2);
      chk("gen_mv_latency2", last_mv, c3 + 3);
      chk("gen_mv_interval", last_mv - prev_mv, 20);
      chk("gen_period2", period, 20);
      chk("gen_no_sh", {31'd0, stuck_high}, 0);
      chk("gen_no_sl", {31'd0, stuck_low}, 0);
   endtask

   task automatic test_change;
      int base;
      base = mv_count;
      hold(1, 7);
      hold(0, 5);
      chk("chg_prev_period", period, 20);
      hold(1, 7);
      hold(0, 5);
      chk("chg_mv_count", mv_count, base + 2);
      chk("chg_period", period, 12);
      chk("chg_high", high_time, 7);
      chk("chg_mv_low", {31'd0, meas_valid}, 0);
   endtask

   task automatic test_stuck_high;
      int c, base;
      c = cyc;
      pwm_in = 1'b1;
      repeat (52) @(negedge clock);
      chk("sh_before", {31'd0, stuck_high}, 0);
      @(negedge clock);
      chk("sh_cycle", cyc, c + 53);
      chk("sh_set", {31'd0, stuck_high}, 1);
      chk("sh_sl_clear", {31'd0, stuck_low}, 0);
      chk("sh_period_held", period, 12);
      chk("sh_high_held", high_time, 7);
      hold(1, 10);
      chk("sh_still", {31'd0, stuck_high}, 1);
      hold(0, 3);
      chk("sh_cleared", {31'd0, stuck_high}, 0);
      base = mv_count;
      hold(1, 3);
      hold(0, 5);
      chk("sh_rise_no_mv", mv_count, base);
   endtask

   task automatic test_stuck_low;
      int base;
      base = mv_count;
      hold(0, 60);
      chk("sl_set", {31'd0, stuck_low}, 1);
      chk("sl_sh_clear", {31'd0, stuck_high}, 0);
      hold(1, 4);
      chk("sl_cleared", {31'd0, stuck_low}, 0);
      chk("sl_first_rise_no_mv", mv_count, base);
      hold(0, 6);
      hold(1, 4);
      hold(0, 6);
      chk("sl_mv_count", mv_count, base + 1);
      chk("sl_period", period, 10);
      chk("sl_high", high_time, 4);
   endtask

   task automatic test_enable;
      int base;
      hold(1, 4);
      base = mv_count;
      enable = 1'b0;
      hold(1, 3);
      enable = 1'b1;
      hold(1, 2);
      hold(0, 5);
      hold(1, 3);
      hold(0, 9);
      chk("en_no_mv", mv_count, base);
      hold(1, 3);
      hold(0, 9);
      chk("en_mv_count", mv_count, base + 1);
      chk("en_period", period, 12);
      chk("en_high", high_time, 3);
   endtask

   task automatic test_async_reset;
      hold(1, 2);
      hold(0, 8);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_period", period, 0);
      chk("ar_high", high_time, 0);
      chk("ar_mv", {31'd0, meas_valid}, 0);
      chk("ar_sh", {31'd0, stuck_high}, 0);
      chk("ar_sl", {31'd0, stuck_low}, 0);
      @(negedge clock);
      reset = 1'b0;
      test_gen_pattern();
   endtask

   task automatic test_invariants;
      chk("inv_consec_mv", consec, 0);
      chk("inv_both_stuck", both, 0);
   endtask

   initial begin
      test_reset();
      test_gen_pattern();
      test_change();
      test_stuck_high();
      test_stuck_low();
      test_enable();
      test_async_reset();
      test_invariants();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures the PWM waveform produced by the team's PWM generator (period and high time, in clock cycles) for closed-loop checking and telemetry.
- Sits directly downstream of the generator. Also accepts an external/asynchronous PWM line.
- Reports one measurement per complete period, with a single-cycle valid strobe.
- Flags a stuck-high or stuck-low line.

Parameters:
- CNT_W, 32, width of the counters and of the period/high_time outputs.
- TIMEOUT, 1000, cycles without an edge before the stuck flags assert. Must satisfy 2 <= TIMEOUT < 2^CNT_W.
- SYNC_STAGES, 2, synchronizer flops on pwm_in (minimum 2).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  measurement enable. Low forces IDLE; outputs hold their values.
- pwm_in  input  1  PWM line under measurement; may be asynchronous.
- period  output  CNT_W  last measured period, in cycles (rise to rise).
- high_time  output  CNT_W  last measured high time, in cycles (rise to fall).
- meas_valid  output  1  one-cycle pulse when period/high_time update.
- stuck_high  output  1  line held high for TIMEOUT cycles.
- stuck_low  output  1  line held low for TIMEOUT cycles.

Behaviour:
- Reset (asynchronous): period=0, high_time=0, meas_valid=0, stuck_high=0, stuck_low=0, counter=0, synchronizer flops=0, state=IDLE.
- Input path:
  - pwm_in passes through SYNC_STAGES flops to give s.
  - One more flop gives s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Latency from a pwm_in edge to the rise/fall cycle is SYNC_STAGES+1 clocks.
- Counter cnt:
  - cnt <= 1 on the rise cycle.
  - Otherwise cnt <= cnt+1 while in HIGH or LOW.
  - Saturates at TIMEOUT and never wraps.
- State machine:
  - IDLE: cnt holds. On rise, go to HIGH (cnt<=1). The first rise after reset, enable, or timeout produces no measurement.
  - HIGH: on fall, high_cap <= cnt and go to LOW. Internal high_cap is not yet visible on the outputs.
  - LOW: on rise, do all of the following in the same edge:
    - period <= cnt
    - high_time <= high_cap
    - meas_valid <= 1
    - cnt <= 1
    - go to HIGH.
  - Timeout: in HIGH or LOW, when cnt == TIMEOUT and there is no edge this cycle:
    - stuck_high <= s; stuck_low <= ~s.
    - Go to IDLE.
    - period and high_time hold their values.
- Stuck flags:
  - Stay set until the next rise or fall; both clear on that edge cycle.
  - Never both set at once.
  - Also cleared when enable=0.
- Timing check: for a generator output with 20-cycle period and 2-cycle high time, period=20 and high_time=2 exactly.
- Boundary conditions:
  - Edge and timeout in the same cycle: the edge wins and no flag is set.
  - Minimum measurable high time or low time is 1 cycle.
  - meas_valid is never high on two consecutive cycles unless period==1. That case is impossible because the minimum period is 2.
  - enable falling mid-measurement: the partial measurement is discarded, state goes to IDLE, and no meas_valid is produced.
  - Reset mid-operation: everything returns to reset values immediately.
  - pwm_in glitches shorter than one clock may be lost. That is acceptable.

Decomposition:
- Shared package pwm_pkg:
  - state enum {IDLE, HIGH, LOW}.
  - default CNT_W, TIMEOUT and SYNC_STAGES constants.
- Sub-module pwm_edge_sync:
  - SYNC_STAGES synchronizer plus delay flop.
  - Outputs s, rise, fall.
  - Reusable by other PWM-input blocks.
- pwm_capture holds the FSM, the counter, the capture registers and the flags.

Test Plan:
- Reset, then drive the generator pattern (high 2 cycles / low 18 cycles, repeating) -> first meas_valid after the second rise+3 clocks; period=20, high_time=2; meas_valid then exactly every 20 cycles; no stuck flags.
- Change to high 7 / low 5 -> next complete period reports period=12, high_time=7; outputs hold between pulses.
- TIMEOUT=50, pwm_in held high after a rise -> stuck_high=1 exactly 50 counted cycles after the rise, state IDLE, period/high_time unchanged; a following fall clears stuck_high; the next rise produces no meas_valid.
- pwm_in held low for more than TIMEOUT -> stuck_low=1, stuck_high=0; a rise clears it; the second subsequent rise yields a valid measurement.
- Deassert enable mid-HIGH for 3 cycles, then reassert -> no meas_valid for the interrupted period; next full period reports correct values.
- Assert reset asynchronously mid-LOW (between clock edges) -> all outputs 0 immediately; after release, behaviour matches the first scenario.
